// File: rtl/m_tx_fcs.sv
// m_tx_fcs: MII nibble transmit framer (preamble/SFD, CRC-32 FCS, IFG, underrun abort); TX_FCS_PAD_EN enables short-frame padding
module m_tx_fcs #(
  parameter int IFG_NIBBLES = 24,
  parameter int MIN_NIBBLES = 120
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       TxStart,
  input  logic [3:0] TxData,
  input  logic       TxValid,
  input  logic       TxLast,
  output logic       TxReady,
  output logic [3:0] MTxD,
  output logic       MTxEn,
  output logic       MTxErr,
  output logic       Busy,
  output logic       Done,
  output logic       Abort
);
`ifdef TX_FCS_PAD_EN
  localparam bit PAD_EN = 1'b1;
`else
  localparam bit PAD_EN = 1'b0;
`endif
  typedef enum logic [2:0] {IDLE, PRE, SFD, DATA, PAD, FCS, ERR, IFG} state_t;
  state_t      state, state_nxt;
  logic [15:0] cnt, cnt_nxt;
  logic [11:0] dcnt, dcnt_nxt, dcnt_inc;
  logic [31:0] crc, crc_nxt, fcs;
  logic [3:0]  d_nxt;
  logic        en_nxt, err_nxt, done_nxt, abort_nxt;

  function automatic logic [31:0] crc4(input logic [31:0] c, input logic [3:0] d);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 4; i++) r = {r[30:0], 1'b0} ^ ((r[31] ^ d[i]) ? 32'h04C11DB7 : 32'h0);
    return r;
  endfunction

  assign TxReady  = state == DATA;
  assign Busy     = state != IDLE;
  assign dcnt_inc = (dcnt == 12'hFFF) ? dcnt : dcnt + 12'd1;

  // complemented, bit-reversed CRC: nibble k of the FCS is fcs[4k+3:4k]
  always_comb for (int i = 0; i < 32; i++) fcs[i] = ~crc[31-i];

  // next state and next registered MII outputs
  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    dcnt_nxt  = dcnt;
    crc_nxt   = crc;
    d_nxt     = 4'h0;
    en_nxt    = 1'b0;
    err_nxt   = 1'b0;
    done_nxt  = 1'b0;
    abort_nxt = 1'b0;
    case (state)
      IDLE: if (TxStart) begin
        state_nxt = PRE;
        cnt_nxt   = 16'd0;
      end
      PRE: begin
        d_nxt     = 4'h5;
        en_nxt    = 1'b1;
        cnt_nxt   = cnt + 16'd1;
        state_nxt = (cnt == 16'd14) ? SFD : PRE;
      end
      SFD: begin
        d_nxt     = 4'hD;
        en_nxt    = 1'b1;
        crc_nxt   = '1;
        dcnt_nxt  = 12'd0;
        state_nxt = DATA;
      end
      DATA: begin
        en_nxt = 1'b1;
        if (TxValid) begin
          d_nxt    = TxData;
          crc_nxt  = crc4(crc, TxData);
          dcnt_nxt = dcnt_inc;
          cnt_nxt  = 16'd0;
          if (TxLast) state_nxt = (PAD_EN && dcnt_inc < 12'(MIN_NIBBLES)) ? PAD : FCS;
        end else begin
          err_nxt   = 1'b1;
          state_nxt = ERR;
        end
      end
      PAD: begin
        en_nxt    = 1'b1;
        crc_nxt   = crc4(crc, 4'h0);
        dcnt_nxt  = dcnt_inc;
        state_nxt = (dcnt_inc >= 12'(MIN_NIBBLES)) ? FCS : PAD;
      end
      FCS: begin
        cnt_nxt = cnt + 16'd1;
        if (cnt == 16'd8) begin
          done_nxt  = 1'b1;
          cnt_nxt   = 16'd0;
          state_nxt = IFG;
        end else begin
          en_nxt = 1'b1;
          d_nxt  = fcs[{cnt[2:0], 2'b00} +: 4];
        end
      end
      ERR: begin
        abort_nxt = 1'b1;
        cnt_nxt   = 16'd0;
        state_nxt = IFG;
      end
      IFG: begin
        cnt_nxt   = cnt + 16'd1;
        state_nxt = (cnt == 16'(IFG_NIBBLES - 3)) ? IDLE : IFG;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // state, counters, CRC and registered outputs
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= 16'd0;
      dcnt   <= 12'd0;
      crc    <= '1;
      MTxD   <= 4'h0;
      MTxEn  <= 1'b0;
      MTxErr <= 1'b0;
      Done   <= 1'b0;
      Abort  <= 1'b0;
    end else begin
      state  <= state_nxt;
      cnt    <= cnt_nxt;
      dcnt   <= dcnt_nxt;
      crc    <= crc_nxt;
      MTxD   <= d_nxt;
      MTxEn  <= en_nxt;
      MTxErr <= err_nxt;
      Done   <= done_nxt;
      Abort  <= abort_nxt;
    end
  end
endmodule

// File: tb/tb_m_tx_fcs.sv
// tb_m_tx_fcs: directed self-checking bench for the m_tx_fcs MII framer
module tb_m_tx_fcs;
  logic       Clk = 0, Reset = 1, TxStart = 0, TxValid = 0, TxLast = 0;
  logic [3:0] TxData = 0;
  logic       TxReady, MTxEn, MTxErr, Busy, Done, Abort;
  logic [3:0] MTxD;
  int total = 0, bad = 0;
  int cyc = 0;
  logic [3:0] cur [64];
  logic [3:0] fcs_exp [8] = '{4'h6, 4'h2, 4'h9, 4'h3, 4'h4, 4'hF, 4'hB, 4'hC};
  logic [3:0] en_q [$];
  int rises [$], falls [$];
  int en_cnt, err_cnt, err_cyc, done_cnt, done_cyc, abort_cnt, abort_cyc, busy_fall;
  logic prev_en = 0, prev_busy = 0;

  m_tx_fcs dut (
    .Clk(Clk), .Reset(Reset), .TxStart(TxStart), .TxData(TxData), .TxValid(TxValid),
    .TxLast(TxLast), .TxReady(TxReady), .MTxD(MTxD), .MTxEn(MTxEn), .MTxErr(MTxErr),
    .Busy(Busy), .Done(Done), .Abort(Abort)
  );

  always #20 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  always @(negedge Clk) begin
    if (MTxEn) begin en_q.push_back(MTxD); en_cnt++; end
    if (MTxErr) begin err_cnt++; err_cyc = cyc; end
    if (MTxEn && !prev_en) rises.push_back(cyc);
    if (!MTxEn && prev_en) falls.push_back(cyc);
    if (Done) begin done_cnt++; done_cyc = cyc; end
    if (Abort) begin abort_cnt++; abort_cyc = cyc; end
    if (!Busy && prev_busy) busy_fall = cyc;
    prev_en = MTxEn;
    prev_busy = Busy;
  end

  task clear_mon;
    en_q.delete(); rises.delete(); falls.delete();
    en_cnt = 0; err_cnt = 0; err_cyc = -1; done_cnt = 0; done_cyc = -1;
    abort_cnt = 0; abort_cyc = -1; busy_fall = -1;
  endtask

  task load_123;
    for (int i = 0; i < 9; i++) begin cur[2*i] = 4'(i + 1); cur[2*i+1] = 4'h3; end
  endtask

  function automatic logic [31:0] residue(input int from);
    logic [31:0] c, r;
    logic fb;
    c = '1;
    for (int k = from; k < en_q.size(); k++)
      for (int b = 0; b < 4; b++) begin
        fb = c[0] ^ en_q[k][b];
        c = (c >> 1) ^ (fb ? 32'hEDB88320 : 32'h0);
      end
    for (int i = 0; i < 32; i++) r[i] = c[31-i];
    return r;
  endfunction

  task feed(input int n, input bit hold, input int pulse_at, input int under_at, input int rst_at, output int a);
    int i, guard;
    logic rdy;
    i = 0; a = -1;
    @(posedge Clk); #1;
    for (guard = 0; i < n && guard < 300; guard++) begin
      TxStart = hold || guard == 0 || i == pulse_at;
      TxData = cur[i]; TxValid = (i != under_at); TxLast = (i == n - 1); Reset = (i == rst_at);
      @(negedge Clk); rdy = TxReady;
      @(posedge Clk); #1;
      if (guard == 0) a = cyc;
      if (rdy) begin
        if (i == under_at || i == rst_at) break;
        i++;
      end
    end
    TxValid = 0; TxLast = 0; Reset = 0; TxStart = hold;
    total++;
    if (guard >= 300) begin bad++; $display("FAIL feed_timeout got=%0d need=%0d", i, n); end
  endtask

  task wait_idle;
    int k;
    @(negedge Clk);
    for (k = 0; k < 200 && Busy; k++) @(negedge Clk);
    total++;
    if (Busy !== 1'b0) begin bad++; $display("FAIL idle_timeout got=%b exp=0", Busy); end
  endtask

  task test_reset;
    Reset = 1;
    repeat (3) @(posedge Clk);
    @(negedge Clk);
    total += 7;
    if (MTxD !== 4'h0) begin bad++; $display("FAIL rst_mtxd got=%h exp=0", MTxD); end
    if (MTxEn !== 1'b0) begin bad++; $display("FAIL rst_mtxen got=%b exp=0", MTxEn); end
    if (MTxErr !== 1'b0) begin bad++; $display("FAIL rst_mtxerr got=%b exp=0", MTxErr); end
    if (TxReady !== 1'b0) begin bad++; $display("FAIL rst_txready got=%b exp=0", TxReady); end
    if (Busy !== 1'b0) begin bad++; $display("FAIL rst_busy got=%b exp=0", Busy); end
    if (Done !== 1'b0) begin bad++; $display("FAIL rst_done got=%b exp=0", Done); end
    if (Abort !== 1'b0) begin bad++; $display("FAIL rst_abort got=%b exp=0", Abort); end
    @(posedge Clk); #1 Reset = 0;
  endtask

  task test_basic;
    int a;
    logic [3:0] e;
    clear_mon; load_123;
    feed(18, 0, 6, -1, -1, a);
    wait_idle;
    repeat (5) @(negedge Clk);
    total++;
    if (en_cnt != 42) begin bad++; $display("FAIL basic_en_cycles got=%0d exp=42", en_cnt); end
    for (int k = 0; k < 42 && k < en_q.size(); k++) begin
      e = k < 15 ? 4'h5 : k == 15 ? 4'hD : k < 34 ? cur[k-16] : fcs_exp[k-34];
      total++;
      if (en_q[k] !== e) begin bad++; $display("FAIL basic_nib%0d got=%h exp=%h", k, en_q[k], e); end
    end
    total += 8;
    if (rises.size() != 1) begin bad++; $display("FAIL basic_preambles got=%0d exp=1", rises.size()); end
    if (rises[0] != a + 1) begin bad++; $display("FAIL basic_rise got=%0d exp=%0d", rises[0], a + 1); end
    if (falls[0] != a + 43) begin bad++; $display("FAIL basic_fall got=%0d exp=%0d", falls[0], a + 43); end
    if (done_cnt != 1) begin bad++; $display("FAIL basic_done_cnt got=%0d exp=1", done_cnt); end
    if (done_cyc != a + 43) begin bad++; $display("FAIL basic_done_cyc got=%0d exp=%0d", done_cyc, a + 43); end
    if (abort_cnt != 0 || err_cnt != 0) begin bad++; $display("FAIL basic_abort_err got=%0d/%0d exp=0/0", abort_cnt, err_cnt); end
    if (busy_fall != a + 65) begin bad++; $display("FAIL basic_busy_fall got=%0d exp=%0d", busy_fall, a + 65); end
    if (residue(16) !== 32'hC704DD7B) begin bad++; $display("FAIL basic_residue got=%h exp=c704dd7b", residue(16)); end
  endtask

  task test_odd_length;
    int a, ok;
    logic [3:0] alt [13] = '{4'hA, 4'h5, 4'h0, 4'hF, 4'hC, 4'h3, 4'h9, 4'h6, 4'h1, 4'hE, 4'h7, 4'h8, 4'h2};
    clear_mon;
    for (int i = 0; i < 13; i++) cur[i] = alt[i];
    feed(13, 0, -1, -1, -1, a);
    wait_idle;
    ok = 0;
    for (int k = 0; k < 13; k++) if (en_q[16+k] === alt[k]) ok++;
    total += 4;
    if (en_cnt != 37) begin bad++; $display("FAIL odd_en_cycles got=%0d exp=37", en_cnt); end
    if (ok != 13) begin bad++; $display("FAIL odd_data got=%0d exp=13 matching", ok); end
    if (done_cyc != a + 38) begin bad++; $display("FAIL odd_done_cyc got=%0d exp=%0d", done_cyc, a + 38); end
    if (residue(16) !== 32'hC704DD7B) begin bad++; $display("FAIL odd_residue got=%h exp=c704dd7b", residue(16)); end
  endtask

  task test_underrun;
    int a;
    clear_mon; load_123;
    feed(18, 0, -1, 9, -1, a);
    wait_idle;
    repeat (3) @(negedge Clk);
    total += 9;
    if (en_cnt != 26) begin bad++; $display("FAIL und_en_cycles got=%0d exp=26", en_cnt); end
    if (err_cnt != 1) begin bad++; $display("FAIL und_err_cnt got=%0d exp=1", err_cnt); end
    if (err_cyc != a + 26) begin bad++; $display("FAIL und_err_cyc got=%0d exp=%0d", err_cyc, a + 26); end
    if (en_q[25] !== 4'h0) begin bad++; $display("FAIL und_err_mtxd got=%h exp=0", en_q[25]); end
    if (abort_cnt != 1) begin bad++; $display("FAIL und_abort_cnt got=%0d exp=1", abort_cnt); end
    if (abort_cyc != a + 27) begin bad++; $display("FAIL und_abort_cyc got=%0d exp=%0d", abort_cyc, a + 27); end
    if (done_cnt != 0) begin bad++; $display("FAIL und_done got=%0d exp=0", done_cnt); end
    if (falls[0] != a + 27) begin bad++; $display("FAIL und_fall got=%0d exp=%0d", falls[0], a + 27); end
    if (busy_fall != a + 49) begin bad++; $display("FAIL und_busy_fall got=%0d exp=%0d", busy_fall, a + 49); end
  endtask

  task test_back_to_back;
    int a, a2;
    clear_mon; load_123;
    feed(18, 1, -1, -1, -1, a);
    feed(18, 1, -1, -1, -1, a2);
    TxStart = 0;
    wait_idle;
    total += 4;
    if (rises.size() != 2) begin bad++; $display("FAIL b2b_frames got=%0d exp=2", rises.size()); end
    if (rises[1] != falls[0] + 24) begin bad++; $display("FAIL b2b_gap got=%0d exp=24", rises[1] - falls[0]); end
    if (done_cnt != 2) begin bad++; $display("FAIL b2b_done got=%0d exp=2", done_cnt); end
    if (en_cnt != 84) begin bad++; $display("FAIL b2b_en_cycles got=%0d exp=84", en_cnt); end
  endtask

  task test_reset_mid_frame;
    int a;
    clear_mon; load_123;
    feed(18, 0, -1, -1, 4, a);
    @(negedge Clk);
    total += 4;
    if (MTxEn !== 1'b0) begin bad++; $display("FAIL midrst_mtxen got=%b exp=0", MTxEn); end
    if (TxReady !== 1'b0) begin bad++; $display("FAIL midrst_txready got=%b exp=0", TxReady); end
    if (Busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%b exp=0", Busy); end
    if (MTxErr !== 1'b0) begin bad++; $display("FAIL midrst_mtxerr got=%b exp=0", MTxErr); end
    repeat (30) @(negedge Clk);
    total += 2;
    if (done_cnt != 0) begin bad++; $display("FAIL midrst_done got=%0d exp=0", done_cnt); end
    if (abort_cnt != 0) begin bad++; $display("FAIL midrst_abort got=%0d exp=0", abort_cnt); end
  endtask

`ifdef TX_FCS_PAD_EN
  task test_pad;
    int a, nz;
    clear_mon;
    for (int i = 0; i < 28; i++) cur[i] = 4'(i + 1);
    feed(28, 0, -1, -1, -1, a);
    wait_idle;
    nz = 0;
    for (int k = 44; k < 136; k++) if (en_q[k] !== 4'h0) nz++;
    total += 3;
    if (en_cnt != 144) begin bad++; $display("FAIL pad_en_cycles got=%0d exp=144", en_cnt); end
    if (nz != 0) begin bad++; $display("FAIL pad_zeros got=%0d nonzero exp=0", nz); end
    if (residue(16) !== 32'hC704DD7B) begin bad++; $display("FAIL pad_residue got=%h exp=c704dd7b", residue(16)); end
  endtask
`endif

  initial begin
    clear_mon;
    test_reset;
`ifdef TX_FCS_PAD_EN
    test_pad;
    test_underrun;
`else
    test_basic;
    test_odd_length;
    test_underrun;
    test_back_to_back;
    test_reset_mid_frame;
    test_basic;
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
